// File: rtl/miriscv_lsu_if.sv
// ---------------------------------------------------------------------------
// miriscv_lsu_if
// Data-memory port of the load-store unit: a req/gnt request phase followed
// by an rvalid response phase (read data for loads, acknowledge for stores).
//
// Signals
//   req     LSU -> mem   request valid
//   gnt     mem -> LSU   request accepted this cycle
//   rvalid  mem -> LSU   response valid
//   rdata   mem -> LSU   read data (32)
//   we      LSU -> mem   write enable
//   be      LSU -> mem   byte enables (4)
//   addr    LSU -> mem   word-aligned byte address (32)
//   wdata   LSU -> mem   lane-replicated store data (32)
//
// Modports
//   master  the LSU side
//   slave   the memory side
// ---------------------------------------------------------------------------
interface miriscv_lsu_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (
    output req,
    output we,
    output be,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  be,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/miriscv_lsu.sv
// ---------------------------------------------------------------------------
// miriscv_lsu
// Load-store unit. Accepts a memory request from the decoder together with
// the ALU address, stalls the core while the data-memory transaction is in
// flight and returns aligned, extended load data in the response cycle.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in REQ+WAIT before abort (0 = no timeout)
//
// Ports
//   clk_i            clock, rising edge
//   arstn_i          asynchronous active-low reset
//   lsu_req_i        memory request from decoder
//   lsu_we_i         1 = store, 0 = load
//   lsu_size_i       access size: B=0, H=1, W=2, BU=4, HU=5
//   lsu_addr_i       byte address from ALU
//   lsu_data_i       store data (rs2)
//   lsu_data_o       extended load result (valid in the response cycle)
//   lsu_stall_req_o  freezes core/PC while high
//   lsu_exc_o        one-cycle pulse: misaligned, illegal size or timeout
//   data_mem         data-memory port (miriscv_lsu_if.master)
//
// FSM
//   state | meaning
//   IDLE  | no transaction in flight
//   REQ   | request issued, waiting for gnt
//   WAIT  | granted, waiting for rvalid
// ---------------------------------------------------------------------------
module miriscv_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,

  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [2:0]           lsu_size_i,
  input  logic [31:0]          lsu_addr_i,
  input  logic [31:0]          lsu_data_i,
  output logic [31:0]          lsu_data_o,
  output logic                 lsu_stall_req_o,
  output logic                 lsu_exc_o,

  miriscv_lsu_if.master        data_mem
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  // The counter only has to hold values up to TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        misaligned;
  logic        illegal;
  logic        bad;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic        complete;
  logic        timeout_hit;
  logic        abort;
  logic        mem_req;

  // -------------------------------------------------------------------------
  // Request validity
  // -------------------------------------------------------------------------
  always_comb begin
    misaligned = 1'b0;
    if ((lsu_size_i == LDST_H) || (lsu_size_i == LDST_HU)) begin
      misaligned = lsu_addr_i[0];
    end else if (lsu_size_i == LDST_W) begin
      misaligned = (lsu_addr_i[1:0] != 2'b00);
    end
  end

  assign illegal = (lsu_size_i == 3'd3) || (lsu_size_i == 3'd6) || (lsu_size_i == 3'd7);
  assign bad     = misaligned || illegal;

  // -------------------------------------------------------------------------
  // Store path: byte enables and lane-replicated write data
  // -------------------------------------------------------------------------
  always_comb begin
    be = 4'b0000;
    case (lsu_size_i)
      LDST_B, LDST_BU: be = 4'b0001 << lsu_addr_i[1:0];
      LDST_H, LDST_HU: be = 4'b0011 << lsu_addr_i[1:0];
      LDST_W:          be = 4'b1111;
      default:         be = 4'b0000;
    endcase
    if (bad) begin
      be = 4'b0000;
    end
  end

  always_comb begin
    wdata = lsu_data_i;
    case (lsu_size_i[1:0])
      2'd0:    wdata = {4{lsu_data_i[7:0]}};
      2'd1:    wdata = {2{lsu_data_i[15:0]}};
      default: wdata = lsu_data_i;
    endcase
  end

  // -------------------------------------------------------------------------
  // Load path: shift the addressed lane down, then extend
  // -------------------------------------------------------------------------
  assign lane = data_mem.rdata >> {lsu_addr_i[1:0], 3'b000};

  always_comb begin
    load_ext = data_mem.rdata;
    case (lsu_size_i)
      LDST_B:  load_ext = {{24{lane[7]}}, lane[7:0]};
      LDST_BU: load_ext = {24'b0, lane[7:0]};
      LDST_H:  load_ext = {{16{lane[15]}}, lane[15:0]};
      LDST_HU: load_ext = {16'b0, lane[15:0]};
      default: load_ext = data_mem.rdata;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control
  // -------------------------------------------------------------------------
  assign complete    = (state_q == ST_WAIT) && data_mem.rvalid;
  assign timeout_hit = TO_EN && (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
  // A response arriving in the last allowed cycle still completes.
  assign abort       = timeout_hit && !complete;

  always_comb begin
    state_d         = state_q;
    mem_req         = 1'b0;
    lsu_stall_req_o = 1'b0;
    lsu_exc_o       = 1'b0;
    lsu_data_o      = 32'b0;

    case (state_q)
      ST_IDLE: begin
        // Gating with arstn_i keeps the memory port and stall quiet for the
        // whole time reset is held, even if the core still presents a request.
        if (lsu_req_i && arstn_i) begin
          if (bad) begin
            lsu_exc_o = 1'b1;
          end else begin
            mem_req         = 1'b1;
            lsu_stall_req_o = 1'b1;
            state_d         = data_mem.gnt ? ST_WAIT : ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (abort) begin
          lsu_exc_o = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          mem_req         = 1'b1;
          lsu_stall_req_o = 1'b1;
          if (data_mem.gnt) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (complete) begin
          state_d = ST_IDLE;
          if (!lsu_we_i) begin
            lsu_data_o = load_ext;
          end
        end else if (abort) begin
          lsu_exc_o = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          lsu_stall_req_o = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counts cycles spent in REQ and WAIT; any return to IDLE clears it.
  always_comb begin
    cnt_d = '0;
    if (TO_EN && (state_q != ST_IDLE) && (state_d != ST_IDLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory port
  // -------------------------------------------------------------------------
  assign data_mem.req   = mem_req;
  assign data_mem.we    = lsu_we_i;
  assign data_mem.be    = be;
  assign data_mem.addr  = {lsu_addr_i[31:2], 2'b00};
  assign data_mem.wdata = wdata;

endmodule

// File: tb/tb_miriscv_lsu.sv
module tb_miriscv_lsu;

  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_exc_o;

  miriscv_lsu_if mem ();

  miriscv_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i           (clk_i),
    .arstn_i         (arstn_i),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_data_o      (lsu_data_o),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_exc_o       (lsu_exc_o),
    .data_mem        (mem)
  );

  always #5 clk_i = ~clk_i;

  // One transaction: inputs, memory timing (gnt in cycle g, rvalid r cycles
  // later) and the expected outcome. Cycle 0 is the cycle the request appears.
  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
    int          r;
    int          done;   // cycle of completion / abort / exception
    int          req_n;  // cycles with data_req_o high
    logic        exc;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] wexp;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_err = 0;
  int cur   = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec=%0d cyc=%0d: got %h expected %h", name, cur, k, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int g, input int r, input int done, input int req_n,
                              input logic exc, input logic [31:0] data, input logic [3:0] be,
                              input logic [31:0] wexp);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.g = g; v.r = r; v.done = done; v.req_n = req_n; v.exc = exc;
    v.data = data; v.be = be; v.wexp = wexp;
    return v;
  endfunction

  function automatic bit is_bad(input vec_t v);
    int sz;
    int lo;
    sz = int'(v.size);
    lo = int'(v.addr) & 3;
    if (sz == 3 || sz >= 6) return 1'b1;
    if ((sz == 1 || sz == 5) && (lo % 2 != 0)) return 1'b1;
    if (sz == 2 && lo != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: outcome of a transaction from the access rules alone.
  function automatic vec_t model(input vec_t vin);
    vec_t v;
    int nbytes;
    int lo;
    int x;
    logic [31:0] lane;
    v  = vin;
    lo = int'(v.addr) & 3;
    nbytes = (v.size[1:0] == 2'd0) ? 1 : (v.size[1:0] == 2'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) v.wexp[8*i +: 8] = v.wdata[8*(i % nbytes) +: 8];
    if (is_bad(v)) begin
      v.done = 0; v.req_n = 0; v.exc = 1'b1; v.data = 32'h0; v.be = 4'h0;
      return v;
    end
    v.be = 4'((((1 << nbytes) - 1) << lo) & 15);
    v.req_n = (v.g + 1 < T) ? v.g + 1 : T;
    if (v.g + v.r <= T) begin
      v.done = v.g + v.r;
      v.exc  = 1'b0;
      lane   = v.rdata >> (8 * lo);
      case (int'(v.size))
        0: begin x = int'(lane & 32'hFF);   if (x > 127)   x -= 256;   v.data = 32'(x); end
        4: v.data = lane & 32'hFF;
        1: begin x = int'(lane & 32'hFFFF); if (x > 32767) x -= 65536; v.data = 32'(x); end
        5: v.data = lane & 32'hFFFF;
        default: v.data = v.rdata;
      endcase
      if (v.we) v.data = 32'h0;
    end else begin
      v.done = T;
      v.exc  = 1'b1;
      v.data = 32'h0;
    end
    return v;
  endfunction

  // Drives one transaction cycle by cycle; inputs change 1 unit after the
  // rising edge and outputs are checked on the falling edge. Cycles after
  // "done" keep the request low while any late gnt/rvalid is still driven.
  task automatic run(input vec_t v);
    bit bad;
    int last;
    bad  = is_bad(v);
    last = v.done;
    if (!bad && (v.g + v.r > last)) last = v.g + v.r;
    if (!bad && (v.g > last)) last = v.g;
    lsu_we_i   = v.we;
    lsu_size_i = v.size;
    lsu_addr_i = v.addr;
    lsu_data_i = v.wdata;
    for (int k = 0; k <= last; k++) begin
      lsu_req_i  = (k <= v.done);
      mem.gnt    = !bad && (k == v.g);
      mem.rvalid = !bad && (k == v.g + v.r);
      mem.rdata  = mem.rvalid ? v.rdata : $urandom;
      @(negedge clk_i);
      chk("data_req", k, 32'(mem.req), 32'(k < v.req_n));
      chk("stall", k, 32'(lsu_stall_req_o), 32'(k < v.done));
      chk("exc", k, 32'(lsu_exc_o), 32'(v.exc && (k == v.done)));
      chk("lsu_data", k, lsu_data_o, (k == v.done) ? v.data : 32'h0);
      if (k == 0) begin
        chk("be", k, 32'(mem.be), 32'(v.be));
        chk("addr", k, mem.addr, {v.addr[31:2], 2'b00});
        chk("we", k, 32'(mem.we), 32'(v.we));
        if (v.we) chk("wdata", k, mem.wdata, v.wexp);
      end
      @(posedge clk_i);
      #1;
    end
    mem.gnt    = 1'b0;
    mem.rvalid = 1'b0;
  endtask

  // Idle cycles with stray responses on the bus: nothing may move.
  task automatic idle(input int n);
    lsu_req_i = 1'b0;
    mem.gnt   = 1'b0;
    for (int k = 0; k < n; k++) begin
      mem.rvalid = 1'($urandom);
      mem.rdata  = $urandom;
      @(negedge clk_i);
      chk("idle_req", k, 32'(mem.req), 32'h0);
      chk("idle_stall", k, 32'(lsu_stall_req_o), 32'h0);
      chk("idle_exc", k, 32'(lsu_exc_o), 32'h0);
      chk("idle_data", k, lsu_data_o, 32'h0);
      @(posedge clk_i);
      #1;
    end
    mem.rvalid = 1'b0;
  endtask

  initial begin
    vec_t v;

    arstn_i    = 1'b0;
    lsu_req_i  = 1'b0;
    lsu_we_i   = 1'b0;
    lsu_size_i = 3'd0;
    lsu_addr_i = 32'h0;
    lsu_data_i = 32'h0;
    mem.gnt    = 1'b0;
    mem.rvalid = 1'b0;
    mem.rdata  = 32'h0;

    //              we  size  addr          wdata         rdata         g  r  done req_n exc data          be     wexp
    tbl[0]  = mk(1'b0, 3'd2, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 2, 2, 1, 1'b0, 32'hDEAD_BEEF, 4'hF, 32'h0);
    tbl[1]  = mk(1'b0, 3'd0, 32'h0000_2003, 32'h0,        32'h80FF_0000, 0, 1, 1, 1, 1'b0, 32'hFFFF_FF80, 4'h8, 32'h0);
    tbl[2]  = mk(1'b0, 3'd4, 32'h0000_2003, 32'h0,        32'h80FF_0000, 0, 1, 1, 1, 1'b0, 32'h0000_0080, 4'h8, 32'h0);
    tbl[3]  = mk(1'b1, 3'd1, 32'h0000_3002, 32'h1234_ABCD, 32'h5555_5555, 3, 1, 4, 4, 1'b0, 32'h0,         4'hC, 32'hABCD_ABCD);
    tbl[4]  = mk(1'b0, 3'd2, 32'h0000_4001, 32'h0,        32'h0,         0, 1, 0, 0, 1'b1, 32'h0,         4'h0, 32'h0);
    tbl[5]  = mk(1'b0, 3'd3, 32'h0000_4000, 32'h0,        32'h0,         0, 1, 0, 0, 1'b1, 32'h0,         4'h0, 32'h0);
    tbl[6]  = mk(1'b0, 3'd2, 32'h0000_5000, 32'h0,        32'h1111_1111, 0, 7, 4, 1, 1'b1, 32'h0,         4'hF, 32'h0);
    tbl[7]  = mk(1'b0, 3'd1, 32'h0000_6002, 32'h0,        32'h8001_0000, 1, 1, 2, 2, 1'b0, 32'hFFFF_8001, 4'hC, 32'h0);
    tbl[8]  = mk(1'b0, 3'd5, 32'h0000_6000, 32'h0,        32'h1234_F00D, 0, 3, 3, 1, 1'b0, 32'h0000_F00D, 4'h3, 32'h0);
    tbl[9]  = mk(1'b1, 3'd0, 32'h0000_7001, 32'h0000_00A5, 32'h0,        2, 2, 4, 3, 1'b0, 32'h0,         4'h2, 32'hA5A5_A5A5);
    tbl[10] = mk(1'b1, 3'd2, 32'h0000_8000, 32'hCAFE_F00D, 32'h0,        5, 1, 4, 4, 1'b1, 32'h0,         4'hF, 32'hCAFE_F00D);
    tbl[11] = mk(1'b0, 3'd1, 32'h0000_8001, 32'h0,        32'h0,         0, 1, 0, 0, 1'b1, 32'h0,         4'h0, 32'h0);
    tbl[12] = mk(1'b0, 3'd6, 32'h0000_8000, 32'h0,        32'h0,         0, 1, 0, 0, 1'b1, 32'h0,         4'h0, 32'h0);
    tbl[13] = mk(1'b1, 3'd2, 32'h0000_8002, 32'h0,        32'h0,         0, 1, 0, 0, 1'b1, 32'h0,         4'h0, 32'h0);
    tbl[14] = mk(1'b0, 3'd2, 32'h0000_9000, 32'h0,        32'h7777_7777, 1, 4, 4, 2, 1'b1, 32'h0,         4'hF, 32'h0);

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", 0, 32'(mem.req), 32'h0);
    chk("rst_stall", 0, 32'(lsu_stall_req_o), 32'h0);
    chk("rst_exc", 0, 32'(lsu_exc_o), 32'h0);
    chk("rst_data", 0, lsu_data_o, 32'h0);
    arstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < NV; i++) begin
      cur = i;
      run(tbl[i]);
    end
    idle(3);

    // Reset while waiting for the response: port and stall drop at once.
    cur        = 100;
    lsu_we_i   = 1'b0;
    lsu_size_i = 3'd2;
    lsu_addr_i = 32'h0000_A000;
    lsu_req_i  = 1'b1;
    mem.gnt    = 1'b1;
    @(negedge clk_i);
    chk("mid_req", 0, 32'(mem.req), 32'h1);
    @(posedge clk_i);
    #1;
    mem.gnt = 1'b0;
    @(negedge clk_i);
    chk("mid_stall", 1, 32'(lsu_stall_req_o), 32'h1);
    #1;
    arstn_i = 1'b0;
    #1;
    chk("arst_req", 1, 32'(mem.req), 32'h0);
    chk("arst_stall", 1, 32'(lsu_stall_req_o), 32'h0);
    chk("arst_exc", 1, 32'(lsu_exc_o), 32'h0);
    @(posedge clk_i);
    #1;
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    cur = 101;
    v = mk(1'b0, 3'd2, 32'h0000_A004, 32'h0, 32'h0BAD_CAFE, 1, 2, 0, 0, 1'b0, 32'h0, 4'h0, 32'h0);
    run(model(v));

    for (int i = 0; i < 300; i++) begin
      cur     = 200 + i;
      v.we    = 1'($urandom);
      v.size  = 3'($urandom_range(0, 7));
      v.addr  = $urandom;
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.g     = $urandom_range(0, 4);
      v.r     = $urandom_range(1, 5);
      run(model(v));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
